// File: rtl/hex_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hex_scan_ctrl_if
//  Purpose  : Write-side handshake bundle for hex_scan_ctrl. The requester
//             (master) offers a packed hex word plus a leading-zero blanking
//             enable. The controller (slave) answers with wr_ready.
//  Revision : 1.0 - initial release
// ============================================================================
interface hex_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
) ();

  logic                    wr_valid;
  logic                    wr_ready;
  logic [4*NUM_DIGITS-1:0] wr_data;
  logic                    blank_lz;

  modport master (
    output wr_valid,
    output wr_data,
    output blank_lz,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  blank_lz,
    output wr_ready
  );

endinterface
`default_nettype wire

// File: rtl/hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hex_scan_ctrl
//  Purpose  : Time-shares one hex-to-7-segment decoder across NUM_DIGITS
//             displays. An accepted word is copied into a shadow register and
//             walked MSB-first. Every REFRESH_DIV cycles one nibble is decoded
//             and latched into that digit's segment register. Leading zeros
//             may optionally be blanked. frame_done pulses once the last digit
//             has been written.
//  Revision : 1.0 - initial release
// ============================================================================
module hex_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  hex_scan_ctrl_if.slave          wr_if,
  output logic [7*NUM_DIGITS-1:0] o_seg_out,
  output logic                    o_busy,
  output logic                    o_frame_done
);

  localparam int c_IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam int c_DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_IDX_W-1:0] c_IDX_TOP  = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
  localparam logic [6:0]         c_BLANK    = 7'h7F;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_lz_en;
  logic                    r_seen_nz;
  logic [c_IDX_W-1:0]      r_idx;
  logic [c_DIV_W-1:0]      r_div;
  logic [7*NUM_DIGITS-1:0] r_seg;
  logic                    r_busy;
  logic                    r_wr_ready;
  logic                    r_frame_done;

  logic                    w_accept;
  logic                    w_tick;
  logic                    w_last;
  logic [3:0]              w_nibble;
  logic [6:0]              w_dec;
  logic                    w_blank;
  logic [6:0]              w_pat;
  logic                    w_busy_nxt;
  logic                    w_ready_nxt;
  logic                    w_fd_nxt;

  // Scan state register; reset aborts any scan in progress immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the next values of the registered status outputs.
  // wr_ready follows the registered state, never wr_valid directly.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy_nxt  = 1'b0;
    w_ready_nxt = 1'b1;
    w_fd_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wr_if.wr_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt  = (w_state_nxt == S_SCAN);
    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_fd_nxt    = w_last;
  end

  // Refresh tick, current nibble selection and leading-zero blanking.
  always_comb begin
    w_tick   = (r_state == S_SCAN) && (r_div == c_DIV_LAST);
    w_last   = w_tick && (r_idx == '0);
    w_nibble = r_shadow[int'(r_idx)*4 +: 4];
    // Digit 0 is always shown so an all-zero word still displays "0".
    w_blank  = r_lz_en && !r_seen_nz && (w_nibble == 4'h0) && (r_idx != '0);
    w_pat    = w_blank ? c_BLANK : w_dec;
  end

  // The single shared hex decoder, active-low {g,f,e,d,c,b,a}.
  always_comb begin
    w_dec = c_BLANK;
    case (w_nibble)
      4'h0: w_dec = 7'b1000000;
      4'h1: w_dec = 7'b1111001;
      4'h2: w_dec = 7'b0100100;
      4'h3: w_dec = 7'b0110000;
      4'h4: w_dec = 7'b0011001;
      4'h5: w_dec = 7'b0010010;
      4'h6: w_dec = 7'b0000010;
      4'h7: w_dec = 7'b1111000;
      4'h8: w_dec = 7'b0000000;
      4'h9: w_dec = 7'b0011000;
      4'hA: w_dec = 7'b0001000;
      4'hB: w_dec = 7'b0000011;
      4'hC: w_dec = 7'b1000110;
      4'hD: w_dec = 7'b0100001;
      4'hE: w_dec = 7'b0000110;
      4'hF: w_dec = 7'b0001110;
      default: w_dec = c_BLANK;
    endcase
  end

  // Shadow word capture, divider and digit walk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shadow  <= '0;
      r_lz_en   <= 1'b0;
      r_seen_nz <= 1'b0;
      r_idx     <= '0;
      r_div     <= '0;
    end else if (w_accept) begin
      r_shadow  <= wr_if.wr_data;
      r_lz_en   <= wr_if.blank_lz;
      r_seen_nz <= 1'b0;
      r_idx     <= c_IDX_TOP;
      r_div     <= '0;
    end else if (r_state == S_SCAN) begin
      if (w_tick) begin
        r_div <= '0;
        if (w_nibble != 4'h0) begin
          r_seen_nz <= 1'b1;
        end
        if (r_idx != '0) begin
          r_idx <= r_idx - c_IDX_ONE;
        end
      end else begin
        r_div <= r_div + c_DIV_ONE;
      end
    end
  end

  // Per-digit segment registers; only the digit being ticked changes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_seg <= '1;
    end else if (w_tick) begin
      r_seg[int'(r_idx)*7 +: 7] <= w_pat;
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy       <= 1'b0;
      r_wr_ready   <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_wr_ready   <= w_ready_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  assign wr_if.wr_ready = r_wr_ready;
  assign o_seg_out      = r_seg;
  assign o_busy         = r_busy;
  assign o_frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_scan_ctrl
//  Purpose  : Scoreboard bench for hex_scan_ctrl. The driver pushes the
//             expected frame and its accept edge for every word it sends. A
//             negedge monitor rebuilds the expected display for every cycle
//             and compares it with the DUT. A second, small instance covers
//             the mid-scan asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_scan_ctrl;

  localparam int N  = 8;
  localparam int R  = 4;
  localparam int NR = N * R;
  localparam int DW = 4 * N;
  localparam int SW = 7 * N;
  localparam int N2 = 4;

  logic clk     = 1'b0;
  logic resetn  = 1'b0;
  logic resetn2 = 1'b0;
  always #5 clk = ~clk;

  hex_scan_ctrl_if #(.NUM_DIGITS(N))  wif  ();
  hex_scan_ctrl_if #(.NUM_DIGITS(N2)) wif2 ();

  logic [SW-1:0]   seg;
  logic            busy, fd;
  logic [7*N2-1:0] seg2;
  logic            busy2, fd2;

  hex_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_if        (wif),
    .o_seg_out    (seg),
    .o_busy       (busy),
    .o_frame_done (fd)
  );

  hex_scan_ctrl #(.NUM_DIGITS(N2), .REFRESH_DIV(1)) dut2 (
    .clk          (clk),
    .resetn       (resetn2),
    .wr_if        (wif2),
    .o_seg_out    (seg2),
    .o_busy       (busy2),
    .o_frame_done (fd2)
  );

  typedef struct {
    logic [SW-1:0] frame;
    int            e0;
  } item_t;

  item_t         sb_q[$];
  item_t         cur;
  int            cyc      = 0;
  int            free_at  = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  bit            mon_en   = 1'b0;
  logic [SW-1:0] disp     = '1;
  logic [SW-1:0] exp_seg;
  logic [2:0]    exp_st;
  int            d;
  logic [DW-1:0] rw;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Active-low {g,f,e,d,c,b,a} glyphs.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Final display for a word: a digit is blank when blanking is on and it
  // lies above the most significant non-zero digit (digit 0 never blank).
  function automatic logic [SW-1:0] ref_frame(input logic [DW-1:0] w, input logic lz);
    logic [SW-1:0] f;
    int msd = -1;
    for (int k = 0; k < N; k++) if (w[4*k +: 4] != 4'h0) msd = k;
    for (int k = 0; k < N; k++) begin
      if (lz && k > msd && k != 0) f[7*k +: 7] = 7'h7F;
      else                         f[7*k +: 7] = glyph(w[4*k +: 4]);
    end
    return f;
  endfunction

  // Send one word. Until the controller is free, either inject noise on the
  // request lines or hold the real request early; then accept it.
  task automatic send(input logic [DW-1:0] w, input logic lz);
    item_t it;
    bit early     = 1'($urandom_range(0, 1));
    int hold_from = free_at - 1 - int'($urandom_range(1, 6));
    while (cyc + 1 < free_at) begin
      if (early && cyc >= hold_from) begin
        wif.wr_valid = 1'b1; wif.wr_data = w; wif.blank_lz = lz;
      end else begin
        wif.wr_valid = 1'($urandom_range(0, 1));
        wif.wr_data  = DW'($urandom);
        wif.blank_lz = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    if (!early) begin
      wif.wr_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wif.wr_valid = 1'b1; wif.wr_data = w; wif.blank_lz = lz;
    it.frame = ref_frame(w, lz);
    it.e0    = cyc + 1;
    sb_q.push_back(it);
    free_at = it.e0 + NR + 1;
    @(negedge clk);
    wif.wr_valid = 1'b0;
  endtask

  // Monitor: expected display mixes new glyphs (digits already ticked) with
  // the previous frame; status follows the scan window.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() > 0 && sb_q[0].e0 <= cyc) begin
        cur = sb_q[0];
        d   = cyc - cur.e0;
        for (int k = 0; k < N; k++)
          exp_seg[7*k +: 7] = ((N - k) * R <= d) ? cur.frame[7*k +: 7] : disp[7*k +: 7];
        exp_st = (d < NR) ? 3'b100 : 3'b011;
        check("seg_scan", 64'(seg), 64'(exp_seg));
        check("busy_ready_fd_scan", 64'({busy, wif.wr_ready, fd}), 64'(exp_st));
        if (d >= NR) begin
          disp = cur.frame;
          void'(sb_q.pop_front());
        end
      end else begin
        check("seg_idle", 64'(seg), 64'(disp));
        check("busy_ready_fd_idle", 64'({busy, wif.wr_ready, fd}), 64'(3'b010));
      end
    end
  end

  initial begin
    wif.wr_valid  = 1'b0; wif.wr_data  = '0; wif.blank_lz  = 1'b0;
    wif2.wr_valid = 1'b0; wif2.wr_data = '0; wif2.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    resetn  = 1'b1;
    mon_en  = 1'b1;
    free_at = cyc + 1;
    repeat (6) @(negedge clk);

    send(32'h0000_00A1, 1'b0);
    send(32'h0000_0F08, 1'b1);
    send(32'h0000_0000, 1'b1);
    for (int i = 0; i < 12; i++) begin
      rw = DW'($urandom);
      rw = rw >> (4 * $urandom_range(0, 7));
      send(rw, 1'($urandom_range(0, 1)));
    end

    for (int t = 0; t < 200 && sb_q.size() > 0; t++) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;

    // Four digits, one digit per clock, reset two edges into the scan.
    resetn2 = 1'b1;
    @(negedge clk);
    check("d2_ready_after_reset", 64'({busy2, wif2.wr_ready, fd2}), 64'(3'b010));
    check("d2_seg_after_reset", 64'(seg2), 64'(28'hFFFFFFF));
    wif2.wr_valid = 1'b1; wif2.wr_data = 16'h1234; wif2.blank_lz = 1'b0;
    @(posedge clk);
    #1;
    wif2.wr_valid = 1'b0;
    check("d2_busy_at_e0", 64'({busy2, wif2.wr_ready, fd2}), 64'(3'b100));
    @(posedge clk);
    @(posedge clk);
    #1;
    check("d2_seg_at_e0p2", 64'(seg2), 64'({7'h79, 7'h24, 7'h7F, 7'h7F}));
    #2;
    resetn2 = 1'b0;
    #1;
    check("d2_seg_async_reset", 64'(seg2), 64'(28'hFFFFFFF));
    check("d2_status_async_reset", 64'({busy2, wif2.wr_ready, fd2}), 64'(3'b010));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
